// File: rtl/dma_utils_pkg.sv
// rtl/dma_utils_pkg.sv - shared DMA types, constants and strobe helper
package dma_utils_pkg;

    localparam int DMA_ADDR_WIDTH      = 32;
    localparam int DMA_DATA_WIDTH      = 32;
    localparam int DMA_BYTES_WIDTH     = 32;
    localparam int DMA_STRB_WIDTH      = DMA_DATA_WIDTH / 8;
    localparam int DMA_OFS             = $clog2(DMA_STRB_WIDTH);
    localparam int DMA_4KB             = 4096;
    localparam int DMA_FIXED_MAX_BEATS = 16;

    typedef logic [DMA_STRB_WIDTH-1:0] axi_wr_strb_t;
    typedef logic [DMA_ADDR_WIDTH-1:0] axi_addr_t;
    typedef logic [7:0]                axi_alen_t;
    typedef logic [2:0]                axi_size_t;

    typedef enum logic {
        DMA_MODE_INCR  = 1'b0,
        DMA_MODE_FIXED = 1'b1
    } dma_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } dma_strm_st_t;

    typedef struct packed {
        axi_addr_t                  addr;
        logic [DMA_BYTES_WIDTH-1:0] num_bytes;
        dma_mode_t                  mode;
    } s_dma_desc_t;

    typedef struct packed {
        logic         valid;
        axi_addr_t    addr;
        axi_alen_t    alen;
        axi_size_t    size;
        axi_wr_strb_t strb;
        dma_mode_t    mode;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    // Ones from lane off through off+n-1.
    function automatic axi_wr_strb_t gen_strb(input logic [DMA_OFS-1:0] off,
                                              input logic [DMA_OFS:0]   n);
        axi_wr_strb_t s;
        s = '0;
        for (int i = 0; i < DMA_STRB_WIDTH; i++) begin
            s[i] = (i >= int'(off)) && (i < int'(off) + int'(n));
        end
        return s;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - splits the remaining transfer into the next legal burst
module dma_burst_calc
    import dma_utils_pkg::*;
#(
    parameter int BYTES_WIDTH = 32,
    parameter int MAX_BEATS   = 256
) (
    input  logic [11:0]            addr_lo,
    input  logic [BYTES_WIDTH-1:0] num_bytes,
    input  dma_mode_t              mode,
    output axi_alen_t              alen,
    output axi_wr_strb_t           strb,
    output logic [BYTES_WIDTH-1:0] nbytes
);

    localparam int B   = DMA_STRB_WIDTH;
    localparam int OFS = DMA_OFS;

    logic [OFS-1:0]         off;
    logic [12:0]            to_4kb;
    logic [BYTES_WIDTH-1:0] head_room;
    logic [BYTES_WIDTH-1:0] beats_4kb;
    logic [BYTES_WIDTH-1:0] beats;

    // Head / tail / body selection; the 13-bit 4 KB distance makes an aligned page give 4096.
    always_comb begin
        off       = addr_lo[OFS-1:0];
        to_4kb    = 13'(DMA_4KB) - {1'b0, addr_lo};
        head_room = BYTES_WIDTH'(B) - BYTES_WIDTH'(off);
        beats_4kb = BYTES_WIDTH'(to_4kb >> OFS);
        beats     = num_bytes >> OFS;
        alen      = '0;
        strb      = '0;
        nbytes    = '0;
        if (off != '0) begin
            nbytes = (num_bytes < head_room) ? num_bytes : head_room;
            strb   = gen_strb(off, nbytes[OFS:0]);
        end else if (num_bytes < BYTES_WIDTH'(B)) begin
            nbytes = num_bytes;
            strb   = gen_strb('0, nbytes[OFS:0]);
        end else begin
            if (mode == DMA_MODE_FIXED) begin
                if (beats > BYTES_WIDTH'(DMA_FIXED_MAX_BEATS)) beats = BYTES_WIDTH'(DMA_FIXED_MAX_BEATS);
            end else begin
                if (beats > BYTES_WIDTH'(MAX_BEATS)) beats = BYTES_WIDTH'(MAX_BEATS);
                if (beats > beats_4kb)               beats = beats_4kb;
            end
            alen   = 8'(beats - 1'b1);
            strb   = '1;
            nbytes = beats << OFS;
        end
    end

endmodule

// File: rtl/dma_streamer.sv
// rtl/dma_streamer.sv - turns one DMA descriptor into a stream of AXI burst requests
module dma_streamer
    import dma_utils_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32,
    parameter int MAX_BEATS   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dma_go_i,
    input  logic                   dma_abort_i,
    input  logic [ADDR_WIDTH-1:0]  desc_addr_i,
    input  logic [BYTES_WIDTH-1:0] desc_num_bytes_i,
    input  dma_mode_t              desc_mode_i,
    output s_dma_axi_req_t         dma_req_o,
    input  s_dma_axi_resp_t        dma_resp_i,
    output logic                   busy_o,
    output logic                   stream_done_o
);

    localparam int OFS = $clog2(DATA_WIDTH / 8);

    dma_strm_st_t           state;
    dma_strm_st_t           state_next;
    s_dma_desc_t            cur;
    logic                   load;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  calc_addr;
    logic [BYTES_WIDTH-1:0] calc_len;
    dma_mode_t              calc_mode;
    axi_alen_t              calc_alen;
    axi_wr_strb_t           calc_strb;
    logic [BYTES_WIDTH-1:0] calc_nbytes;

    assign accept        = dma_req_o.valid && dma_resp_i.ready;
    assign busy_o        = (state != ST_IDLE);
    assign stream_done_o = (state == ST_DONE);

    // In IDLE the first request is sized straight from the descriptor inputs so it is valid at go+1.
    always_comb begin
        calc_addr = cur.addr;
        calc_len  = cur.num_bytes;
        calc_mode = cur.mode;
        if (state == ST_IDLE) begin
            calc_addr = desc_addr_i;
            calc_len  = desc_num_bytes_i;
            calc_mode = desc_mode_i;
        end
    end

    dma_burst_calc #(
        .BYTES_WIDTH (BYTES_WIDTH),
        .MAX_BEATS   (MAX_BEATS)
    ) u_calc (
        .addr_lo   (calc_addr[11:0]),
        .num_bytes (calc_len),
        .mode      (calc_mode),
        .alen      (calc_alen),
        .strb      (calc_strb),
        .nbytes    (calc_nbytes)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next state; cur holds what remains after the request currently presented.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dma_go_i) begin
                    state_next = ST_RUN;
                    load       = (desc_num_bytes_i != '0);
                end
            end
            ST_RUN: begin
                if (!dma_req_o.valid || accept) begin
                    if (cur.num_bytes == '0 || dma_abort_i) state_next = ST_DONE;
                    else                                    load       = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request register and running address/length; a stalled request is never touched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dma_req_o <= '0;
            cur       <= '0;
        end else begin
            if (state == ST_IDLE && dma_go_i) begin
                cur <= '{addr: desc_addr_i, num_bytes: desc_num_bytes_i, mode: desc_mode_i};
            end
            if (load) begin
                dma_req_o.valid <= 1'b1;
                dma_req_o.addr  <= calc_addr;
                dma_req_o.alen  <= calc_alen;
                dma_req_o.size  <= 3'(OFS);
                dma_req_o.strb  <= calc_strb;
                dma_req_o.mode  <= calc_mode;
                cur.addr        <= (calc_mode == DMA_MODE_INCR) ? calc_addr + ADDR_WIDTH'(calc_nbytes) : calc_addr;
                cur.num_bytes   <= calc_len - calc_nbytes;
                cur.mode        <= calc_mode;
            end else if (accept) begin
                dma_req_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_streamer.sv
// tb/tb_dma_streamer.sv - randomized self-checking bench for dma_streamer
module tb_dma_streamer;
    import dma_utils_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [3:0]  strb;
        dma_mode_t   mode;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            go;
    logic            abort;
    logic [31:0]     desc_addr;
    logic [31:0]     desc_len;
    dma_mode_t       desc_mode;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            busy_o;
    logic            stream_done_o;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   running  = 0;
    bit   done_due = 0;

    dma_streamer dut (
        .clk              (clk),
        .rst              (rst),
        .dma_go_i         (go),
        .dma_abort_i      (abort),
        .desc_addr_i      (desc_addr),
        .desc_num_bytes_i (desc_len),
        .desc_mode_i      (desc_mode),
        .dma_req_o        (req),
        .dma_resp_i       (resp),
        .busy_o           (busy_o),
        .stream_done_o    (stream_done_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: walk the descriptor byte by byte-range, 4-byte beats.
    function automatic void build(input logic [31:0] a, input logic [31:0] len, input dma_mode_t m);
        int unsigned l, n, beats, cap, off, page_beats;
        logic [31:0] ad;
        exp_t e;
        l  = len;
        ad = a;
        while (l > 0) begin
            off = ad % 4;
            if (off != 0) begin
                n      = (4 - off < l) ? 4 - off : l;
                e.alen = 8'd0;
                e.strb = 4'(((1 << n) - 1) << off);
            end else if (l < 4) begin
                n      = l;
                e.alen = 8'd0;
                e.strb = 4'((1 << l) - 1);
            end else begin
                page_beats = (4096 - ad % 4096) / 4;
                if (m == DMA_MODE_FIXED) cap = 16;
                else                     cap = (page_beats < 256) ? page_beats : 256;
                beats  = (l / 4 < cap) ? l / 4 : cap;
                n      = beats * 4;
                e.alen = 8'(beats - 1);
                e.strb = 4'hF;
            end
            e.addr = ad;
            e.mode = m;
            exp_q.push_back(e);
            l = l - n;
            if (m == DMA_MODE_INCR) ad = ad + n;
        end
    endfunction

    // Per-cycle compare against the reference queue.
    always @(negedge clk) begin
        if (!rst) begin
            running  = 0;
            done_due = 0;
            exp_q.delete();
        end else if (done_due) begin
            chk("done_pulse", stream_done_o, 1);
            chk("done_busy", busy_o, 1);
            chk("done_valid", req.valid, 0);
            done_due = 0;
            running  = 0;
            exp_q.delete();
        end else if (running) begin
            chk("run_busy", busy_o, 1);
            chk("run_done", stream_done_o, 0);
            chk("run_valid", req.valid, exp_q.size() != 0);
            if (req.valid && exp_q.size() != 0) begin
                chk("req_addr", req.addr, exp_q[0].addr);
                chk("req_alen", req.alen, exp_q[0].alen);
                chk("req_strb", req.strb, exp_q[0].strb);
                chk("req_size", req.size, 2);
                chk("req_mode", req.mode, exp_q[0].mode);
                if (resp.ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0 || abort) done_due = 1;
                end
            end else if (!req.valid && (exp_q.size() == 0 || abort)) begin
                done_due = 1;
            end
        end else begin
            chk("idle_busy", busy_o, 0);
            chk("idle_valid", req.valid, 0);
            chk("idle_done", stream_done_o, 0);
            if (go) begin
                build(desc_addr, desc_len, desc_mode);
                running = 1;
            end
        end
    end

    task automatic run_desc(input logic [31:0] a, input logic [31:0] len, input dma_mode_t m,
                            input int rdy_pct, input int hold, input int abort_at, input bit spur);
        int k;
        @(posedge clk); #1;
        desc_addr = a;
        desc_len  = len;
        desc_mode = m;
        go        = 1;
        @(posedge clk); #1;
        go = 0;
        for (k = 0; k < 6000; k++) begin
            resp.ready = (k >= hold) && ($urandom_range(0, 99) < rdy_pct);
            abort      = (abort_at >= 0) && (k >= abort_at);
            if (spur) begin
                go = (k == 1);
                if (k == 1) desc_addr = $urandom;
            end
            @(negedge clk);
            if (!busy_o) break;
            @(posedge clk); #1;
        end
        if (k >= 6000) chk("timeout", 1, 0);
        resp.ready = 0;
        abort      = 0;
        go         = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, l;
        rst       = 0;
        go        = 0;
        abort     = 0;
        resp      = '0;
        desc_addr = '0;
        desc_len  = '0;
        desc_mode = DMA_MODE_INCR;

        build(32'h1000, 64, DMA_MODE_INCR);
        chk("pin_a_cnt", exp_q.size(), 1);
        chk("pin_a_alen", exp_q[0].alen, 15);
        chk("pin_a_strb", exp_q[0].strb, 4'hF);
        exp_q.delete();
        build(32'h0, 1024, DMA_MODE_INCR);
        chk("pin_b_alen", exp_q[0].alen, 255);
        exp_q.delete();
        build(32'h1002, 9, DMA_MODE_INCR);
        chk("pin_c_cnt", exp_q.size(), 3);
        chk("pin_c_0", {exp_q[0].addr, exp_q[0].strb}, {32'h1002, 4'hC});
        chk("pin_c_1", {exp_q[1].addr, exp_q[1].strb}, {32'h1004, 4'hF});
        chk("pin_c_2", {exp_q[2].addr, exp_q[2].strb}, {32'h1008, 4'h7});
        exp_q.delete();
        build(32'h0FF0, 32, DMA_MODE_INCR);
        chk("pin_d_0", {exp_q[0].addr, exp_q[0].alen}, {32'h0FF0, 8'd3});
        chk("pin_d_1", {exp_q[1].addr, exp_q[1].alen}, {32'h1000, 8'd3});
        exp_q.delete();
        build(32'h2000, 80, DMA_MODE_FIXED);
        chk("pin_e_0", {exp_q[0].addr, exp_q[0].alen}, {32'h2000, 8'd15});
        chk("pin_e_1", {exp_q[1].addr, exp_q[1].alen}, {32'h2000, 8'd3});
        exp_q.delete();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", stream_done_o, 0);
        @(posedge clk); #1;
        rst = 1;

        run_desc(32'h1000, 64,   DMA_MODE_INCR,  100, 0, -1, 0);
        run_desc(32'h0,    1024, DMA_MODE_INCR,  100, 0, -1, 0);
        run_desc(32'h1002, 9,    DMA_MODE_INCR,  100, 0, -1, 0);
        run_desc(32'h0FF0, 32,   DMA_MODE_INCR,  100, 0, -1, 0);
        run_desc(32'h1002, 9,    DMA_MODE_INCR,  100, 5, -1, 0);
        run_desc(32'h1002, 64,   DMA_MODE_INCR,  100, 5, 2,  0);
        run_desc(32'h0,    0,    DMA_MODE_INCR,  100, 0, 0,  0);
        run_desc(32'h2000, 80,   DMA_MODE_FIXED, 100, 0, -1, 0);
        run_desc(32'h3000, 0,    DMA_MODE_INCR,  100, 0, -1, 0);
        run_desc(32'h0,    2000, DMA_MODE_INCR,  70,  0, -1, 0);
        run_desc(32'h3000, 256,  DMA_MODE_INCR,  50,  0, -1, 1);
        run_desc(32'h2001, 10,   DMA_MODE_FIXED, 60,  2, -1, 0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 32'h3FFF);
            if ($urandom_range(0, 2) == 0) a = (a & 32'hFFFF_F000) + 32'h1000 - $urandom_range(1, 40);
            l = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 600);
            run_desc(a, l, dma_mode_t'($urandom_range(0, 1)), $urandom_range(40, 100),
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, 0);
        end

        @(posedge clk); #1;
        desc_addr = 32'h4000;
        desc_len  = 400;
        desc_mode = DMA_MODE_INCR;
        go        = 1;
        @(posedge clk); #1;
        go = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_streamer.md
Name: dma_streamer

Overview:
- Converts one DMA descriptor (start address, byte count, burst mode) into a sequence of AXI-legal burst requests on the s_dma_axi_req_t / s_dma_axi_resp_t handshake.
- Sits directly upstream of the DMA AXI interface block. The design instantiates two copies: a read streamer (source descriptor) and a write streamer (destination descriptor).
- Splits transfers at unaligned head/tail bytes, at 4 KB boundaries and at the maximum burst length, so each request carries one strb valid for every beat.

Parameters:
- ADDR_WIDTH, 32, address width (matches `DMA_ADDR_WIDTH`).
- DATA_WIDTH, 32, AXI data width; B = DATA_WIDTH/8 bytes per beat, OFS = log2(B).
- BYTES_WIDTH, 32, width of the byte-count field.
- MAX_BEATS, 256, maximum INCR burst length in beats (1..256).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (0 = reset). Single clock domain.
- dma_go_i  in  1  start pulse; sampled only in ST_IDLE.
- dma_abort_i  in  1  abort request (level).
- desc_addr_i  in  ADDR_WIDTH  start address; captured on go.
- desc_num_bytes_i  in  BYTES_WIDTH  bytes to move; captured on go.
- desc_mode_i  in  dma_mode_t  DMA_MODE_INCR or DMA_MODE_FIXED; captured on go.
- dma_req_o  out  s_dma_axi_req_t  valid/addr/alen/size/strb/mode to the AXI interface.
- dma_resp_i  in  s_dma_axi_resp_t  .ready = request accepted this cycle.
- busy_o  out  1  high from go until the done pulse.
- stream_done_o  out  1  one-cycle pulse when the descriptor has completed or been aborted.

Behaviour:
- Reset values: dma_req_o = '0, busy_o = 0, stream_done_o = 0, state = ST_IDLE.
- Reset mid-operation abandons the descriptor silently; no done pulse is generated.
- States are ST_IDLE, ST_RUN and ST_DONE.
- ST_IDLE:
  - dma_go_i=1 captures the descriptor, sets busy_o=1 and goes to ST_RUN.
  - dma_go_i while busy is ignored.
- ST_RUN:
  - dma_req_o is registered. The first request is valid in cycle go+1.
  - Accept = valid && ready. On accept, the next request is presented in the following cycle (back-to-back, no bubble).
  - While valid && !ready, every field of dma_req_o holds stable and valid stays high. This is an AXI valid/ready rule; abort does not override it.
- Request calculation from the current address A and remaining byte count L (size is always OFS):
  - Head: A[OFS-1:0] != 0. Single beat, alen=0, bytes n = min(B - off, L), strb has ones from bit off through off+n-1.
  - Tail: A aligned and L < B. Single beat, alen=0, n = L, strb = (1<<L)-1.
  - Body, INCR: beats = min(L>>OFS, MAX_BEATS, (4096 - A[11:0])>>OFS), alen = beats-1, strb all ones, n = beats*B.
  - Body, FIXED: beats = min(L>>OFS, 16); the 4 KB boundary check is not applied.
- Updates on accept:
  - L -= n.
  - INCR: A += n.
  - FIXED: A is unchanged, so an unaligned FIXED address produces single-beat head-type requests throughout.
- ST_RUN exits to ST_DONE when any of the following holds:
  - the accepted request makes L == 0;
  - dma_abort_i=1 and no request is pending (valid low);
  - dma_abort_i=1 and the pending request is accepted.
- desc_num_bytes_i == 0: no request is issued; ST_RUN goes to ST_DONE in cycle go+1.
- ST_DONE: stream_done_o=1 for exactly one cycle, busy_o=0 next, return to ST_IDLE.
- Arithmetic:
  - L and A are unsigned with no wrap-around.
  - The 4 KB computation uses a 13-bit intermediate so that A[11:0]=0 yields 4096.
  - A descriptor crossing the top of the address space is out of scope.

Decomposition:
- Additions to dma_utils_pkg:
  - dma_strm_st_t enum (ST_IDLE, ST_RUN, ST_DONE).
  - s_dma_desc_t {addr, num_bytes, mode}.
  - Function gen_strb(off, n) returning axi_wr_strb_t.
  - Constant DMA_4KB = 4096.
  - Constant DMA_FIXED_MAX_BEATS = 16.
- One natural sub-module: dma_burst_calc. It is purely combinational: (A, L, mode) -> (alen, strb, n). This keeps the FSM small and lets verification unit-test the split rules.

Test Plan:
All cases use DATA_WIDTH=32 (B=4).
- INCR aligned, addr 0x1000, 64 B: one request {addr 0x1000, alen 15, strb 0xF, size 2}; done pulses one cycle after accept; 1024 B at 0x0 gives alen 255.
- INCR unaligned, addr 0x1002, 9 B: three requests {0x1002, alen 0, 0xC}, {0x1004, alen 0, 0xF}, {0x1008, alen 0, 0x7}, then done.
- 4 KB split, addr 0x0FF0, 32 B: {0x0FF0, alen 3}, then {0x1000, alen 3}.
- Backpressure: ready held low for 5 cycles on the first request; valid, addr, alen and strb stay identical each cycle; the next request appears the cycle after ready.
- Abort: dma_abort_i asserted while valid && !ready; the request is held until ready; done pulses next; no further valid. Abort in a cycle with no pending request gives done the next cycle.
- FIXED and zero-length:
  - FIXED, addr 0x2000, 80 B: {0x2000, alen 15}, then {0x2000, alen 3}, mode FIXED.
  - num_bytes 0: valid never asserted, stream_done_o at go+2, busy_o low afterwards.
